// File: rtl/modulo_product_param_pkg.sv
// -----------------------------------------------------------------------------
// modprod_pkg
//   Shared types and constants for the bit-serial modular multiplier.
//   - state_e       : controller states IDLE -> CALC -> DONE -> IDLE
//   - DEFAULT_WIDTH : operand width used when the parent does not override it
//   - cnt_width()   : width of the processed-bit counter. It must be able to
//                     hold WIDTH, because the multiplier has WIDTH+1 bits
//                     (indices 0..WIDTH). One spare bit keeps the compare
//                     against WIDTH free of wrap-around.
// -----------------------------------------------------------------------------
package modprod_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 256;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1) + 1;
    endfunction

endpackage

// File: rtl/mod_add_sub.sv
// -----------------------------------------------------------------------------
// mod_add_sub
//   Combinational modular adder: y = (x0 + x1) mod n. Both addends must be
//   below n, so their sum is below 2n and a single conditional subtraction is
//   enough to bring it back into range.
//   Ports:
//     x0_i  in  WIDTH  first addend  (< n)
//     x1_i  in  WIDTH  second addend (< n)
//     n_i   in  WIDTH  modulus
//     y_o   out WIDTH  (x0 + x1) mod n
// -----------------------------------------------------------------------------
module mod_add_sub
    import modprod_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x0_i,
    input  logic [WIDTH-1:0] x1_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] y_o
);

    // The sum is formed one bit wider than the operands so that the carry out
    // of the top bit is kept when n is close to 2^WIDTH.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, x0_i} + {1'b0, x1_i};
    assign diff = sum - {1'b0, n_i};

    // When sum >= n the difference is below n, so its top bit is always zero
    // and truncation to WIDTH bits is exact.
    assign y_o = (sum >= {1'b0, n_i}) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];

endmodule

// File: rtl/modulo_product_param.sv
// -----------------------------------------------------------------------------
// modulo_product_param
//   Bit-serial modular multiplier: o_result = (i_a * i_b) mod i_n.
//   The multiplier i_b is scanned LSB first, one bit per clock. The running
//   power-of-two multiple t = a * 2^i mod n is doubled every cycle and added
//   into the accumulator m whenever bit i of b is set.
//
//   Parameters:
//     WIDTH       width of i_n, i_a and o_result; i_b is WIDTH+1 bits
//     EARLY_EXIT  1: stop as soon as no set bit of b remains unprocessed
//
//   Ports:
//     i_clk     in   1        clock, rising edge
//     i_rst_n   in   1        asynchronous reset, active low
//     i_start   in   1        start request, only looked at while idle
//     i_n       in   WIDTH    modulus (n >= 2)
//     i_a       in   WIDTH    multiplicand (a < n)
//     i_b       in   WIDTH+1  multiplier
//     o_result  out  WIDTH    product mod n, valid with o_finish, then held
//     o_finish  out  1        one-cycle completion pulse
//     o_busy    out  1        high while bits are being processed
//
//   Timing, with the accepting edge numbered 0: bit i is processed at edge i+1.
//   With EARLY_EXIT=0 the last bit is bit WIDTH. With EARLY_EXIT=1 the last bit
//   is the highest set bit of b, or bit 0 when b is zero. o_finish is high
//   during the cycle after the last bit.
// -----------------------------------------------------------------------------
module modulo_product_param
    import modprod_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH:0]   i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finish,
    output logic             o_busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [WIDTH-1:0] n_q;       // latched modulus
    logic [WIDTH-1:0] t_q;       // a * 2^i mod n
    logic [WIDTH-1:0] m_q;       // partial product mod n
    logic [WIDTH:0]   b_q;       // unprocessed multiplier bits, current bit at [0]
    logic [CW-1:0]    cnt_q;     // index of the bit being processed
    logic [WIDTH-1:0] result_q;
    logic             finish_q;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_add;     // (m + t) mod n
    logic [WIDTH-1:0] m_d;       // accumulator after the current bit
    logic [WIDTH-1:0] t_d;       // (2t) mod n
    logic             last_bit;

    mod_add_sub #(.WIDTH(WIDTH)) u_acc (
        .x0_i (m_q),
        .x1_i (t_q),
        .n_i  (n_q),
        .y_o  (m_add)
    );

    mod_add_sub #(.WIDTH(WIDTH)) u_dbl (
        .x0_i (t_q),
        .x1_i (t_q),
        .n_i  (n_q),
        .y_o  (t_d)
    );

    assign m_d = b_q[0] ? m_add : m_q;

    // The counter bound guarantees termination even when the operand
    // preconditions are violated. In early-exit mode the bits above the
    // current one are inspected before the shift.
    assign last_bit = (cnt_q == CW'(WIDTH)) ||
                      (EARLY_EXIT && (b_q[WIDTH:1] == '0));

    // ------------------------------------------------------------------
    // Controller: state, datapath registers and outputs in one process
    // ------------------------------------------------------------------
    // NOTE: every register is cleared by the asynchronous reset, and all
    // sequential updates are non-blocking so that each reads the
    // pre-edge value of the others.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            t_q      <= '0;
            m_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        n_q     <= i_n;
                        t_q     <= i_a;
                        m_q     <= '0;
                        b_q     <= i_b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    m_q   <= m_d;
                    t_q   <= t_d;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        result_q <= m_d;
                        finish_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Start requests are ignored here; a held start is
                    // accepted on the following idle edge.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_result = result_q;
    assign o_finish = finish_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_modulo_product_param.sv
module tb_modulo_product_param;

    // Instances: 0/1 WIDTH=8, 2/3 WIDTH=16, 4/5 WIDTH=256; odd index = EARLY_EXIT
    localparam int NI = 6;

    typedef struct packed {
        logic [255:0] res;
        logic [31:0]  lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start_s [NI];
    logic [255:0] n_s     [NI];
    logic [255:0] a_s     [NI];
    logic [256:0] b_s     [NI];
    logic [255:0] res_s   [NI];
    logic         fin_s   [NI];
    logic         busy_s  [NI];

    logic [7:0]   r0, r1;
    logic [15:0]  r2, r3;
    logic [255:0] r4, r5;

    assign res_s[0] = 256'(r0);
    assign res_s[1] = 256'(r1);
    assign res_s[2] = 256'(r2);
    assign res_s[3] = 256'(r3);
    assign res_s[4] = r4;
    assign res_s[5] = r5;

    modulo_product_param #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[0]), .i_n(n_s[0][7:0]),
        .i_a(a_s[0][7:0]), .i_b(b_s[0][8:0]), .o_result(r0), .o_finish(fin_s[0]), .o_busy(busy_s[0]));
    modulo_product_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[1]), .i_n(n_s[1][7:0]),
        .i_a(a_s[1][7:0]), .i_b(b_s[1][8:0]), .o_result(r1), .o_finish(fin_s[1]), .o_busy(busy_s[1]));
    modulo_product_param #(.WIDTH(16), .EARLY_EXIT(1'b0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[2]), .i_n(n_s[2][15:0]),
        .i_a(a_s[2][15:0]), .i_b(b_s[2][16:0]), .o_result(r2), .o_finish(fin_s[2]), .o_busy(busy_s[2]));
    modulo_product_param #(.WIDTH(16), .EARLY_EXIT(1'b1)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[3]), .i_n(n_s[3][15:0]),
        .i_a(a_s[3][15:0]), .i_b(b_s[3][16:0]), .o_result(r3), .o_finish(fin_s[3]), .o_busy(busy_s[3]));
    modulo_product_param #(.WIDTH(256), .EARLY_EXIT(1'b0)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[4]), .i_n(n_s[4]),
        .i_a(a_s[4]), .i_b(b_s[4]), .o_result(r4), .o_finish(fin_s[4]), .o_busy(busy_s[4]));
    modulo_product_param #(.WIDTH(256), .EARLY_EXIT(1'b1)) u5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[5]), .i_n(n_s[5]),
        .i_a(a_s[5]), .i_b(b_s[5]), .o_result(r5), .o_finish(fin_s[5]), .o_busy(busy_s[5]));

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t sb [NI][$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int wid(input int k);
        return (k < 2) ? 8 : (k < 4) ? 16 : 256;
    endfunction

    function automatic bit ee(input int k);
        return k[0];
    endfunction

    // Reference model: plain wide arithmetic and the latency rule.
    function automatic logic [255:0] ref_mod(input logic [255:0] n, input logic [255:0] a,
                                             input logic [256:0] b);
        logic [513:0] p;
        p = 514'(a) * 514'(b);
        return 256'(p % 514'(n));
    endfunction

    function automatic int ref_lat(input int k, input logic [256:0] b);
        int hi;
        hi = 0;
        if (!ee(k)) return wid(k) + 1;
        for (int i = 0; i <= 256; i++) if (b[i]) hi = i;
        return hi + 1;
    endfunction

    // ------------------------------------------------------------------
    // Clock, cycle counter, watchdog
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on every finish pulse
    // ------------------------------------------------------------------
    int   acc_cyc   [NI];
    int   busy_len  [NI];
    logic busy_prev [NI];

    initial begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            acc_cyc[k] = 0; busy_len[k] = 0; busy_prev[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    busy_prev[k] = 1'b0;
                    busy_len[k]  = 0;
                end else begin
                    if (busy_s[k] && !busy_prev[k]) begin
                        acc_cyc[k]  = cyc;
                        busy_len[k] = 0;
                    end
                    if (busy_s[k]) busy_len[k]++;
                    if (fin_s[k]) begin
                        if (sb[k].size() == 0) begin
                            check($sformatf("spurious_finish[%0d]", k), 256'(fin_s[k]), 256'd0);
                        end else begin
                            e = sb[k].pop_front();
                            check($sformatf("result[%0d]", k), res_s[k], e.res);
                            check($sformatf("latency[%0d]", k), 256'(cyc - acc_cyc[k]), 256'(e.lat));
                            check($sformatf("busy_len[%0d]", k), 256'(busy_len[k]), 256'(e.lat));
                            check($sformatf("busy_at_finish[%0d]", k), 256'(busy_s[k]), 256'd0);
                        end
                    end
                    busy_prev[k] = busy_s[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input int k, input logic [255:0] n, input logic [255:0] a,
                         input logic [256:0] b);
        n_s[k] = n;
        a_s[k] = a;
        b_s[k] = b;
    endtask

    task automatic scramble(input int k);
        drive(k, {8{$urandom()}}, {8{$urandom()}}, {9{$urandom()}});
    endtask

    task automatic wait_drain(input int k);
        int g;
        g = 0;
        while (sb[k].size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("drain[%0d]", k), 256'(sb[k].size()), 256'd0);
    endtask

    task automatic run_dir(input int k, input logic [255:0] n, input logic [255:0] a,
                           input logic [256:0] b, input logic [255:0] exp_res, input int exp_lat);
        exp_t e;
        @(negedge clk);
        drive(k, n, a, b);
        start_s[k] = 1'b1;
        e.res = exp_res;
        e.lat = 32'(exp_lat);
        sb[k].push_back(e);
        @(negedge clk);
        start_s[k] = 1'b0;
        scramble(k);
        wait_drain(k);
    endtask

    task automatic gen(input int k, output logic [255:0] n, output logic [255:0] a,
                       output logic [256:0] b);
        int w;
        logic [255:0] rn, ra, mask;
        logic [256:0] rb, bmask;
        w = wid(k);
        for (int i = 0; i < 8; i++) begin
            rn[32*i +: 32] = $urandom();
            ra[32*i +: 32] = $urandom();
            rb[32*i +: 32] = $urandom();
        end
        rb[256] = 1'($urandom_range(0, 1));
        mask  = (w == 256) ? '1 : ((256'd1 << w) - 256'd1);
        bmask = (257'd1 << (w + 1)) - 257'd1;
        rn = rn & mask;
        if (rn < 256'd2) rn = 256'd2;
        n = rn;
        a = ra % rn;
        case ($urandom_range(0, 4))
            0:       b = (rb & bmask) >> $urandom_range(0, w);
            1:       b = 257'd1 << w;
            2:       b = 257'(rb[3:0]);
            default: b = rb & bmask;
        endcase
    endtask

    // Back-to-back operations with i_start held high throughout.
    task automatic run_rand(input int k, input int nops);
        logic [255:0] n, a;
        logic [256:0] b;
        exp_t e;
        int g;
        gen(k, n, a, b);
        @(negedge clk);
        drive(k, n, a, b);
        start_s[k] = 1'b1;
        for (int j = 0; j < nops; j++) begin
            g = 0;
            while (busy_s[k] !== 1'b1 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (busy_s[k] !== 1'b1) begin
                check($sformatf("accept[%0d]", k), 256'(busy_s[k]), 256'd1);
                break;
            end
            e.res = ref_mod(n, a, b);
            e.lat = 32'(ref_lat(k, b));
            sb[k].push_back(e);
            gen(k, n, a, b);
            drive(k, n, a, b);
            g = 0;
            while (busy_s[k] === 1'b1 && g < 1000) begin
                @(negedge clk);
                g++;
            end
        end
        start_s[k] = 1'b0;
        wait_drain(k);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_s[k] = 1'b0;
            drive(k, '0, '0, '0);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_result[%0d]", k), res_s[k], 256'd0);
            check($sformatf("reset_finish[%0d]", k), 256'(fin_s[k]), 256'd0);
            check($sformatf("reset_busy[%0d]", k), 256'(busy_s[k]), 256'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        run_dir(0, 256'd251, 256'd200, 257'd256, 256'd247, 9);
        run_dir(1, 256'd251, 256'd200, 257'd3,   256'd98,  2);
        run_dir(1, 256'd251, 256'd200, 257'd0,   256'd0,   1);
        run_dir(0, 256'd13,  256'd12,  257'd511, 256'd9,   9);
        run_dir(4,
            256'hca35_7e1b_90d2_44af_1c3e_58b7_d609_2fe4_a87c_13d5_6b90_e2f1_4a37_c85d_09b6_f831,
            256'hc6b6_2a90_5f3e_81d7_4c09_e6a2_b315_78fd_02c4_9e6b_d173_58a0_6f2e_c914_b75d_3dfb,
            257'd1 << 256,
            ref_mod(256'hca35_7e1b_90d2_44af_1c3e_58b7_d609_2fe4_a87c_13d5_6b90_e2f1_4a37_c85d_09b6_f831,
                    256'hc6b6_2a90_5f3e_81d7_4c09_e6a2_b315_78fd_02c4_9e6b_d173_58a0_6f2e_c914_b75d_3dfb,
                    257'd1 << 256),
            257);

        // A second start pulse in the middle of an operation is ignored
        begin
            exp_t e;
            @(negedge clk);
            drive(0, 256'd251, 256'd200, 257'd256);
            start_s[0] = 1'b1;
            e.res = 256'd247;
            e.lat = 32'd9;
            sb[0].push_back(e);
            @(negedge clk);
            start_s[0] = 1'b0;
            repeat (3) @(negedge clk);
            drive(0, 256'd13, 256'd12, 257'd511);
            start_s[0] = 1'b1;
            @(negedge clk);
            start_s[0] = 1'b0;
            wait_drain(0);
        end

        // Reset in the middle of an operation aborts it without a finish pulse
        @(negedge clk);
        drive(0, 256'd13, 256'd12, 257'd511);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        for (int k = 0; k < NI; k++) sb[k].delete();
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("abort_result[%0d]", k), res_s[k], 256'd0);
            check($sformatf("abort_busy[%0d]", k), 256'(busy_s[k]), 256'd0);
            check($sformatf("abort_finish[%0d]", k), 256'(fin_s[k]), 256'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_dir(0, 256'd13, 256'd12, 257'd511, 256'd9, 9);

        // Randomised back-to-back traffic on every configuration in parallel
        fork
            run_rand(0, 300);
            run_rand(1, 300);
            run_rand(2, 1000);
            run_rand(3, 1000);
            run_rand(4, 120);
            run_rand(5, 120);
        join

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
